// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem request and instruction output register.
// Optional: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_old,
    input  logic        inst_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_fault
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_old_q, pc_old_d;
    logic        valid_q, valid_d;
    logic        fault_q;
    logic        misaligned;
    logic        can_issue;
    logic        fire;
    logic        consume;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_d;
    assign misaligned     = (redirect_pc[1:0] != 2'b00);
    assign misalign_fault = fault_q;
`else
    assign misaligned = 1'b0;
    assign fault_q    = 1'b0;
`endif

    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign pc_old     = pc_old_q;

    // Next-state, handshake and output-register update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_old_d = pc_old_q;
        valid_d  = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d  = fault_q;
`endif
        can_issue = (state_q == S_FETCH) && (!valid_q || inst_ready);
        imem_req  = can_issue && !rst;
        consume   = valid_q && inst_ready;
        fire      = imem_req && imem_ack && !redirect;

        if (redirect) begin
            valid_d = 1'b0;
            if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
                fault_d = 1'b1;
`endif
                state_d = S_HALTED;
            end else begin
                pc_d    = redirect_pc & 32'hFFFF_FFFC;
                state_d = halt ? S_HALTED : S_FETCH;
            end
        end else begin
            if (fire) begin
                inst_d   = imem_rdata;
                pc_old_d = pc_q;
                valid_d  = 1'b1;
                pc_d     = pc_q + 32'd4;
            end else if (consume) begin
                valid_d = 1'b0;
            end

            unique case (state_q)
                S_FETCH: begin
                    if (halt)
                        state_d = S_HALTED;
                    else if (!can_issue)
                        state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (halt)
                        state_d = S_HALTED;
                    else if (inst_ready)
                        state_d = S_FETCH;
                end
                S_HALTED: begin
                    if (!halt && !fault_q)
                        state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_VECTOR;
            inst_q   <= 32'd0;
            pc_old_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_old_q <= pc_old_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            fault_q <= 1'b0;
        else
            fault_q <= fault_d;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios then random traffic
// compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, halt, redirect, imem_ack, inst_ready;
    logic [31:0] redirect_pc, imem_rdata, imem_addr, inst, pc_old;
    logic        imem_req, inst_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_rdata = imem_ack ? memf(imem_addr) : 32'hDEAD_0BAD;

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .halt(halt),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst(inst),
        .pc_old(pc_old),
        .inst_ready(inst_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_fault(misalign_fault)
`endif
    );

    // Model: run = may fetch, wait = stalled output awaiting consume, stop = halted
    localparam int RUN  = 0;
    localparam int WAIT = 1;
    localparam int STOP = 2;

    logic [31:0] m_pc, m_inst, m_pcold;
    bit          m_valid, m_fault;
    int          m_mode;

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_inst  = 32'd0;
        m_pcold = 32'd0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_mode  = RUN;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit h, input bit rd,
                        input logic [31:0] rp, input bit a, input bit rdy);
        bit exp_req, mis, stalled;
        rst         = r;
        halt        = h;
        redirect    = rd;
        redirect_pc = rp;
        imem_ack    = a;
        inst_ready  = rdy;
        #2;
        exp_req = !r && (m_mode == RUN) && (!m_valid || rdy);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req)
            chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("inst", inst, m_inst);
        chk("pc_old", pc_old, m_pcold);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, m_fault});
        mis = (rp[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (r) begin
            model_reset();
        end else if (rd) begin
            m_valid = 1'b0;
            if (mis) begin
                m_fault = 1'b1;
                m_mode  = STOP;
            end else begin
                m_pc   = {rp[31:2], 2'b00};
                m_mode = h ? STOP : RUN;
            end
        end else begin
            stalled = m_valid && !rdy;
            if (exp_req && a) begin
                m_inst  = memf(m_pc);
                m_pcold = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (m_mode == STOP)
                m_mode = (!h && !m_fault) ? RUN : STOP;
            else if (h)
                m_mode = STOP;
            else if (m_mode == RUN)
                m_mode = stalled ? WAIT : RUN;
            else
                m_mode = rdy ? RUN : WAIT;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Streaming after reset: 0,4,8,C
        step(1, 0, 0, 32'd0, 1, 1);
        repeat (5) step(0, 0, 0, 32'd0, 1, 1);

        // Back-pressure: bubble then resume at 4
        step(1, 0, 0, 32'd0, 0, 0);
        step(0, 0, 0, 32'd0, 1, 1);
        repeat (3) step(0, 0, 0, 32'd0, 1, 0);
        step(0, 0, 0, 32'd0, 1, 1);
        repeat (2) step(0, 0, 0, 32'd0, 1, 1);

        // Redirect while 0x8 is being acked
        step(1, 0, 0, 32'd0, 0, 0);
        step(0, 0, 0, 32'd0, 1, 1);
        step(0, 0, 0, 32'd0, 1, 1);
        step(0, 0, 1, 32'h0000_0100, 1, 1);
        repeat (2) step(0, 0, 0, 32'd0, 1, 1);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 1);
        step(0, 0, 0, 32'd0, 1, 1);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        step(0, 0, 0, 32'd0, 1, 1);

        // Halt with draining
        step(0, 1, 0, 32'd0, 1, 0);
        step(0, 1, 0, 32'd0, 1, 1);
        repeat (2) step(0, 1, 0, 32'd0, 1, 0);
        repeat (3) step(0, 0, 0, 32'd0, 1, 1);

        // Misaligned redirect target
        step(0, 0, 1, 32'h0000_0102, 1, 1);
        repeat (3) step(0, 0, 0, 32'd0, 1, 1);
        step(1, 0, 0, 32'd0, 1, 1);

        // Random traffic
        repeat (600) begin
            logic [31:0] rp;
            rp = $urandom;
            if ($urandom_range(0, 7) != 0)
                rp[1:0] = 2'b00;
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 rp,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
